ga_grade_scan: RTL
==================

Name: ga_grade_scan

Overview:
Multi-cycle grade classifier for packed multivectors of a parametrised algebra, ALG_DIM basis vectors and 2^ALG_DIM blades. It scans LANES components per cycle and reports dominant grade, grade-occupancy mask, saturated peak magnitude and type flags. It sits beside the GA coprocessor register file, uses valid/ready on both sides, and serves the classify and normalise paths.

Parameters:
MV_WIDTH, 16, bits per signed two's-complement component
ALG_DIM, 5, basis-vector count; BLADES = 2^ALG_DIM components; grades 0..ALG_DIM
LANES, 4, components examined per scan cycle; must divide BLADES; BEATS = BLADES/LANES
GW (derived), $clog2(ALG_DIM+1), grade field width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
flush_i  in  1  synchronous abort, returns to IDLE
in_valid_i  in  1  request valid
in_ready_o  out  1  request accepted when in_valid_i & in_ready_o
in_mv_i  in  MV_WIDTH*BLADES  multivector; component 0 (scalar) in MSB slice; grade-sorted canonical order
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed when out_valid_o & out_ready_i
out_grade_o  out  GW  dominant grade
out_grade_mask_o  out  ALG_DIM+1  bit g set iff any grade-g component is nonzero
out_max_mag_o  out  MV_WIDTH  largest saturated |component|
out_is_zero_o  out  1  all components zero
out_is_scalar_o  out  1  mask == 1
out_is_blade_o  out  1  exactly one mask bit set (homogeneous grade)
out_is_even_o  out  1  mask nonzero and only even-grade bits set

Behaviour:
- Grade of index k: g such that sum_{j<g}C(ALG_DIM,j) <= k < sum_{j<=g}C(ALG_DIM,j). Boundaries are elaboration-time constants.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: in_ready_o=1. On accept: latch in_mv_i, clear the per-grade max registers (ALG_DIM+1 x MV_WIDTH), beat counter=0, go to SCAN.
  - SCAN: each cycle, process components beat*LANES..beat*LANES+LANES-1 and increment the counter. At beat BEATS-1, go to DONE.
  - DONE: out_valid_o=1; outputs and latched data are held stable until out_ready_i, then go to IDLE.
- in_ready_o=0 outside IDLE. No accept is possible in the DONE-to-IDLE cycle.
- Latency: out_valid_o is high BEATS cycles after the accepting edge (8 at defaults). Throughput is one result per BEATS+2 cycles.
- Magnitude is saturating absolute value: the most-negative value maps to 2^(MV_WIDTH-1)-1; other values give their exact |x|.
- Per-lane update: grade_max[g] = max(grade_max[g], |x|). Lanes sharing a grade in one beat are max-reduced before update.
- Occupancy: mask bit g = (grade_max[g] != 0). The mask, flags, dominant grade and max magnitude are computed combinationally from the grade_max registers in DONE.
- Dominant grade = argmax of grade_max; ties resolve to the lowest grade. All-zero input gives grade 0, mask 0, max 0, is_zero=1, and scalar/blade/even flags all 0.
- flush_i in any state forces IDLE next cycle, drops the result, and leaves out_valid_o low. flush_i coincident with in_valid_i in IDLE: no accept.
- rst_i (asynchronous, any state, including mid-scan): state=IDLE, counter=0, grade_max=0. All outputs low except in_ready_o, which goes high after reset deasserts.
- in_mv_i is sampled only at accept; later changes are ignored.

Test Plan:
- Scalar=5, rest 0, defaults -> out_valid 8 cycles after accept; grade=0, mask=6'b000001, max=5, is_scalar=1, is_blade=1, is_even=1, is_zero=0.
- e2=-300, e12=200 -> grade=1, mask=6'b000110, max=300, is_blade=0, is_even=0.
- e123oi=16'h8000 only -> grade=5, mask=6'b100000, max=16'h7FFF, is_blade=1, is_even=0.
- Tie: scalar=100, e12=-100 -> grade=0, mask=6'b000101, is_even=1. All-zero input -> is_zero=1, grade=0, mask=0.
- Backpressure: out_ready low 5 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored; one accept occurs after the IDLE return.
- rst_i pulsed at scan beat 3 -> outputs low immediately, in_ready=1 after release, next request yields correct result; flush_i at beat 5 -> no out_valid for that request.

Source files
------------

// File: rtl/ga_grade_scan.sv
// ga_grade_scan: multi-cycle grade classifier for packed multivectors.
//
// Scans a 2^ALG_DIM-component multivector LANES components per cycle, keeps a
// running saturated |x| maximum per grade, and in DONE reports the dominant
// grade, the grade-occupancy mask, the peak magnitude and the type flags.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             synchronous abort back to IDLE, result dropped
//   in_valid_i/in_ready_o/in_mv_i
//                       request handshake; component 0 (scalar) in MSB slice
//   out_valid_o/out_ready_i
//                       result handshake
//   out_grade_o         dominant grade (ties -> lowest grade)
//   out_grade_mask_o    bit g set iff some grade-g component is nonzero
//   out_max_mag_o       largest saturated |component|
//   out_is_zero_o, out_is_scalar_o, out_is_blade_o, out_is_even_o
//                       type flags derived from the mask
module ga_grade_scan #(
    parameter int unsigned MV_WIDTH = 16,
    parameter int unsigned ALG_DIM  = 5,
    parameter int unsigned LANES    = 4,
    localparam int unsigned BLADES  = 1 << ALG_DIM,
    localparam int unsigned GW      = $clog2(ALG_DIM + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [MV_WIDTH*BLADES-1:0] in_mv_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [GW-1:0]              out_grade_o,
    output logic [ALG_DIM:0]           out_grade_mask_o,
    output logic [MV_WIDTH-1:0]        out_max_mag_o,
    output logic                       out_is_zero_o,
    output logic                       out_is_scalar_o,
    output logic                       out_is_blade_o,
    output logic                       out_is_even_o
);

    localparam int unsigned BEATS = BLADES / LANES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned IW    = ALG_DIM;
    localparam int unsigned NG    = ALG_DIM + 1;

    // Grade of canonical index k: walk the cumulative binomial boundaries.
    function automatic int unsigned grade_of(input int unsigned k);
        int unsigned c;
        int unsigned cum;
        int unsigned g;
        c   = 1;
        cum = 1;
        g   = 0;
        for (int unsigned j = 1; j <= ALG_DIM; j++) begin
            if (k >= cum) begin
                g   = j;
                c   = c * (ALG_DIM - j + 1) / j;
                cum = cum + c;
            end
        end
        return g;
    endfunction

    // Saturating absolute value: the most-negative code maps to max positive.
    function automatic logic [MV_WIDTH-1:0] sat_abs(input logic [MV_WIDTH-1:0] x);
        logic [MV_WIDTH-1:0] r;
        r = x;
        if (x[MV_WIDTH-1]) begin
            if (x[MV_WIDTH-2:0] == '0) begin
                r = {1'b0, {(MV_WIDTH - 1){1'b1}}};
            end else begin
                r = -x;
            end
        end
        return r;
    endfunction

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                     state_q;
    logic [BW-1:0]              beat_q;
    logic [MV_WIDTH*BLADES-1:0] mv_q;
    logic [MV_WIDTH-1:0]        gmax_q [NG];
    logic [MV_WIDTH-1:0]        gmax_d [NG];

    logic [MV_WIDTH-1:0]        comp      [BLADES];
    logic [GW-1:0]              grade_lut [BLADES];

    logic [IW-1:0]              lane_idx   [LANES];
    logic [MV_WIDTH-1:0]        lane_mag   [LANES];
    logic [GW-1:0]              lane_grade [LANES];

    logic [NG-1:0]              mask;
    logic [GW-1:0]              best_grade;
    logic [MV_WIDTH-1:0]        best_mag;
    logic                       any_odd;
    logic                       done;

    // Unpacked view of the latched vector and the constant index->grade table.
    for (genvar k = 0; k < BLADES; k++) begin : g_comp
        assign comp[k]      = mv_q[MV_WIDTH*(BLADES-k)-1 -: MV_WIDTH];
        assign grade_lut[k] = GW'(grade_of(k));
    end

    // Lanes of the current beat.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_idx[l]   = IW'(beat_q) * IW'(LANES) + IW'(l);
            lane_mag[l]   = sat_abs(comp[lane_idx[l]]);
            lane_grade[l] = grade_lut[lane_idx[l]];
        end
    end

    // Per-grade running max; lanes that share a grade reduce in sequence.
    always_comb begin
        for (int unsigned g = 0; g < NG; g++) begin
            gmax_d[g] = gmax_q[g];
            for (int unsigned l = 0; l < LANES; l++) begin
                if (lane_grade[l] == GW'(g) && lane_mag[l] > gmax_d[g]) begin
                    gmax_d[g] = lane_mag[l];
                end
            end
        end
    end

    // Result summary from the per-grade maxima; strict '>' keeps the lowest
    // grade on ties.
    always_comb begin
        best_grade = '0;
        best_mag   = gmax_q[0];
        mask       = '0;
        any_odd    = 1'b0;
        for (int unsigned g = 0; g < NG; g++) begin
            mask[g] = (gmax_q[g] != '0);
            if (g[0]) begin
                any_odd = any_odd | mask[g];
            end
            if (g > 0 && gmax_q[g] > best_mag) begin
                best_mag   = gmax_q[g];
                best_grade = GW'(g);
            end
        end
    end

    assign done = (state_q == StDone);

    // Result outputs are gated so everything reads low outside DONE.
    assign in_ready_o       = (state_q == StIdle) && !rst_i;
    assign out_valid_o      = done;
    assign out_grade_o      = done ? best_grade : '0;
    assign out_grade_mask_o = done ? mask : '0;
    assign out_max_mag_o    = done ? best_mag : '0;
    assign out_is_zero_o    = done && (mask == '0);
    assign out_is_scalar_o  = done && (mask == NG'(1));
    assign out_is_blade_o   = done && $onehot(mask);
    assign out_is_even_o    = done && (mask != '0) && !any_odd;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            beat_q  <= '0;
            mv_q    <= '0;
            for (int unsigned g = 0; g < NG; g++) begin
                gmax_q[g] <= '0;
            end
        end else if (flush_i) begin
            state_q <= StIdle;
            beat_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        mv_q    <= in_mv_i;
                        beat_q  <= '0;
                        state_q <= StScan;
                        for (int unsigned g = 0; g < NG; g++) begin
                            gmax_q[g] <= '0;
                        end
                    end
                end
                StScan: begin
                    for (int unsigned g = 0; g < NG; g++) begin
                        gmax_q[g] <= gmax_d[g];
                    end
                    beat_q <= beat_q + BW'(1);
                    if (beat_q == BW'(BEATS - 1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
